// File: rtl/slc3_mem_pkg.sv
// Shared types and helpers for the SLC-3 external-SRAM responder.
package slc3_mem_pkg;
  localparam int WORD_W     = 16;
  localparam int ADDR_W_EXT = 20;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, LOAD} sram_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic oor;
  } sram_req_t;

  // Active-low byte enables: a lane whose enable is high keeps its old byte.
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic ub_n,
                                                   input logic lb_n);
    byte_merge = {ub_n ? old_w[WORD_W-1:WORD_W/2] : new_w[WORD_W-1:WORD_W/2],
                  lb_n ? old_w[WORD_W/2-1:0]      : new_w[WORD_W/2-1:0]};
  endfunction
endpackage

// File: rtl/sram_responder_if.sv
// SRAM bus seen by the responder: CPU-side controls, split data ports and the preload port.
interface sram_responder_if #(parameter int AW = 10);
  logic                                  CE, UB, LB, OE, WE;
  logic [slc3_mem_pkg::ADDR_W_EXT-1:0]   ADDR;
  logic [slc3_mem_pkg::WORD_W-1:0]       Data_in;
  logic [slc3_mem_pkg::WORD_W-1:0]       Data_out;
  logic                                  Data_oe, Ready, Oor;
  logic                                  Load_en;
  logic [AW-1:0]                         Load_addr;
  logic [slc3_mem_pkg::WORD_W-1:0]       Load_data;

  modport master (output CE, UB, LB, OE, WE, ADDR, Data_in, Load_en, Load_addr, Load_data,
                  input  Data_out, Data_oe, Ready, Oor);
  modport slave  (input  CE, UB, LB, OE, WE, ADDR, Data_in, Load_en, Load_addr, Load_data,
                  output Data_out, Data_oe, Ready, Oor);
endinterface

// File: rtl/sram_byte_array.sv
// DEPTH x 16 storage: one byte-masked write port, one combinational read port, never cleared.
module sram_byte_array
  import slc3_mem_pkg::*;
#(parameter int AW = 10)
(
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= byte_merge(mem[waddr], wdata, ~be[1], ~be[0]);

  assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// Memory end of the SLC-3 SRAM bus: request decode, read wait states, byte writes, preload.
module sram_responder
  import slc3_mem_pkg::*;
#(
  parameter int AW     = 10,
  parameter int RD_LAT = 2
)
(
  input  logic           Clk,
  input  logic           Reset,
  sram_responder_if.slave bus
);
  localparam logic [2:0] LAT = 3'(RD_LAT);

  sram_state_t            state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [ADDR_W_EXT-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]      dout_q, dout_d, rdata, wdata;
  logic                   oe_q, oe_d, rdy_q, rdy_d, oor_q, oor_d;
  logic                   we;
  logic [1:0]             be;
  logic [AW-1:0]          waddr;
  sram_req_t              req;
  logic                   addr_chg;

  // WE dominates OE, so a bus with both low decodes as a write only.
  assign req = '{rd:  ~bus.CE & ~bus.OE & bus.WE,
                 wr:  ~bus.CE & ~bus.WE,
                 oor: |bus.ADDR[ADDR_W_EXT-1:AW]};
  assign addr_chg = bus.ADDR != addr_q;

  sram_byte_array #(.AW(AW)) u_array (
    .clk  (Clk),
    .we   (we),
    .be   (be),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(bus.ADDR[AW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = 1'b0;
    rdy_d   = 1'b0;
    oor_d   = 1'b0;
    we      = 1'b0;
    be      = 2'b00;
    waddr   = bus.ADDR[AW-1:0];
    wdata   = bus.Data_in;
    unique case (state_q)
      IDLE: begin
        if (bus.Load_en) begin
          state_d = LOAD;
          we      = ~Reset;
          be      = 2'b11;
          waddr   = bus.Load_addr;
          wdata   = bus.Load_data;
        end else if (req.wr) begin
          // The only commit point of a WE pulse; WR_HOLD absorbs the rest of it.
          state_d = WR_HOLD;
          oor_d   = req.oor;
          we      = ~Reset & ~req.oor;
          be      = {~bus.UB, ~bus.LB};
        end else if (req.rd) begin
          state_d = RD_WAIT;
          cnt_d   = 3'd1;
          addr_d  = bus.ADDR;
          oor_d   = req.oor;
        end
      end
      RD_WAIT: begin
        if (!req.rd || addr_chg) state_d = IDLE;
        else if (cnt_q >= LAT) begin
          state_d = RD_DRIVE;
          dout_d  = req.oor ? '0 : rdata;
          oe_d    = 1'b1;
          rdy_d   = 1'b1;
        end else cnt_d = cnt_q + 3'd1;
      end
      RD_DRIVE: begin
        if (!req.rd) state_d = IDLE;
        else if (addr_chg) begin
          state_d = RD_WAIT;
          cnt_d   = 3'd1;
          addr_d  = bus.ADDR;
          oor_d   = req.oor;
        end else begin
          dout_d = req.oor ? '0 : rdata;
          oe_d   = 1'b1;
          rdy_d  = 1'b1;
        end
      end
      WR_HOLD: if (!req.wr) state_d = IDLE;
      LOAD: begin
        if (bus.Load_en) begin
          we    = ~Reset;
          be    = 2'b11;
          waddr = bus.Load_addr;
          wdata = bus.Load_data;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Data_out = dout_q;
  assign bus.Data_oe  = oe_q;
  assign bus.Ready    = rdy_q;
  assign bus.Oor      = oor_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized checks of sram_responder against a word-array reference model.
module tb_sram_responder;
  localparam int AW     = 10;
  localparam int RD_LAT = 2;

  logic Clk = 1'b0;
  logic Reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [15:0] model [1<<AW];

  sram_responder_if #(.AW(AW)) bus ();

  sram_responder #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oor(input logic [19:0] a);
    return (a >> AW) != 0;
  endfunction

  task automatic bus_idle();
    bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1; bus.UB = 1'b1; bus.LB = 1'b1;
    bus.Load_en = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [15:0] d);
    bus.Load_en   = 1'b1;
    bus.Load_addr = AW'(a);
    bus.Load_data = d;
    step();
    model[a] = d;
  endtask

  task automatic load_end(input string tag);
    bus_idle();
    step();
    chk({tag, " ready_low"}, 32'(bus.Ready), 32'd0);
  endtask

  task automatic do_read(input logic [19:0] a, input int hold, input string tag);
    logic [15:0] exp;
    logic        oor;
    int          n;
    oor = is_oor(a);
    exp = oor ? 16'h0000 : model[a[AW-1:0]];
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1; bus.ADDR = a;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk({tag, " oor"}, 32'(bus.Oor), 32'(oor));
      if (n == 2) chk({tag, " oor_pulse"}, 32'(bus.Oor), 32'd0);
    end while (!bus.Ready && n < 20);
    chk({tag, " latency"}, 32'(n - 1), 32'(RD_LAT));
    chk({tag, " data"}, 32'(bus.Data_out), 32'(exp));
    chk({tag, " oe"}, 32'(bus.Data_oe), 32'd1);
    repeat (hold) step();
    if (hold > 0) chk({tag, " hold"}, {15'd0, bus.Ready, bus.Data_out}, {15'd0, 1'b1, exp});
    bus_idle();
    step();
    chk({tag, " release"}, {30'd0, bus.Data_oe, bus.Ready}, 32'd0);
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input int cyc, input logic oe_low, input string tag);
    logic oor, oe_seen;
    oor = is_oor(a);
    bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = ~oe_low; bus.UB = ub; bus.LB = lb;
    bus.ADDR = a; bus.Data_in = d;
    step();
    chk({tag, " oor"}, 32'(bus.Oor), 32'(oor));
    oe_seen = bus.Data_oe;
    for (int i = 1; i < cyc; i++) begin
      bus.Data_in = ~d;  // a second commit in the same pulse would leave this behind
      step();
      oe_seen |= bus.Data_oe;
      if (i == 1) chk({tag, " oor_pulse"}, 32'(bus.Oor), 32'd0);
    end
    bus_idle();
    step();
    oe_seen |= bus.Data_oe;
    chk({tag, " oe_never"}, 32'(oe_seen), 32'd0);
    if (!oor) begin
      if (!ub) model[a[AW-1:0]][15:8] = d[15:8];
      if (!lb) model[a[AW-1:0]][7:0]  = d[7:0];
    end
  endtask

  initial begin
    int n;
    bus_idle();
    bus.ADDR = '0; bus.Data_in = '0; bus.Load_addr = '0; bus.Load_data = '0;
    Reset = 1'b1;
    step(); step();
    chk("reset outputs", {12'd0, bus.Data_oe, bus.Ready, bus.Oor, 1'b0, bus.Data_out}, 32'd0);
    Reset = 1'b0;
    step();

    // 1: preload burst then read back
    load_word(0, 16'h1234);
    load_word(1, 16'h5678);
    load_word(2, 16'h9ABC);
    load_end("preload");
    do_read(20'h00001, 1, "rd1");
    do_read(20'h00000, 0, "rd0");

    // 2: upper-byte write, long pulse commits once
    load_word(4, 16'hAAAA);
    load_end("preload4");
    do_write(20'h00004, 16'h55FF, 1'b0, 1'b1, 4, 1'b0, "bytewr");
    do_read(20'h00004, 0, "rd4");

    // 3: address change while waiting
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1; bus.ADDR = 20'h00000;
    step();
    bus.ADDR = 20'h00002;
    step();
    chk("addrchg no_ready_1", 32'(bus.Ready), 32'd0);
    step();
    chk("addrchg no_ready_2", 32'(bus.Ready), 32'd0);
    n = 0;
    while (!bus.Ready && n < 20) begin step(); n++; end
    chk("addrchg ready", 32'(bus.Ready), 32'd1);
    chk("addrchg data", 32'(bus.Data_out), 32'h9ABC);
    // address change while driving restarts the full latency
    bus.ADDR = 20'h00001;
    n = 0;
    do begin step(); n++; end while (!bus.Ready && n < 20);
    chk("drivechg latency", 32'(n - 1), 32'(RD_LAT));
    chk("drivechg data", 32'(bus.Data_out), 32'h5678);
    bus_idle();
    step();

    // 4: OE and WE both low is a write
    do_write(20'h00003, 16'h0F0F, 1'b0, 1'b0, 3, 1'b1, "oewe");
    do_read(20'h00003, 0, "rd3");

    // 5: out-of-range read and write
    do_read(20'h00400, 1, "oor rd");
    do_write(20'h00400, 16'hBEEF, 1'b0, 1'b0, 2, 1'b0, "oor wr");
    do_read(20'h00000, 0, "alias rd0");

    // 6: reset mid-read
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1; bus.ADDR = 20'h00001;
    step();
    Reset = 1'b1;
    step();
    chk("rst midread", {30'd0, bus.Data_oe, bus.Ready}, 32'd0);
    Reset = 1'b0;
    bus_idle();
    step();
    do_read(20'h00000, 0, "post rst rd0");

    // randomized traffic over a preloaded region
    for (int i = 16; i < 32; i++) load_word(i, 16'($urandom));
    load_end("rand preload");
    for (int it = 0; it < 60; it++) begin
      int op, idx;
      op  = $urandom_range(0, 9);
      idx = 16 + $urandom_range(0, 15);
      if (op <= 4) do_read(20'(idx), $urandom_range(0, 2), "rand rd");
      else if (op <= 7)
        do_write(20'(idx), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), 1'($urandom_range(0, 1)), "rand wr");
      else if (op == 8) begin
        // a CPU write presented during a load must be ignored
        bus.CE = 1'b0; bus.WE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0;
        bus.ADDR = 20'(16 + $urandom_range(0, 15)); bus.Data_in = 16'($urandom);
        load_word(idx, 16'($urandom));
        load_end("rand load");
      end else begin
        logic [19:0] a;
        a = 20'((1 << (AW + $urandom_range(0, 19 - AW))) | idx);
        if ($urandom_range(0, 1) == 1) do_read(a, 0, "rand oor rd");
        else do_write(a, 16'($urandom), 1'b0, 1'b0, 1, 1'b0, "rand oor wr");
      end
    end
    for (int i = 16; i < 32; i++) do_read(20'(i), 0, "final rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
